// File: rtl/ws2812_pixel_feeder.sv
// Frame feeder for a WS2812 LED chain: holds one colour register per LED and
// streams brightness-scaled {G,R,B} words to a serializer over a valid/ready handshake.
module ws2812_pixel_feeder #(
  parameter int LED_COUNT = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_rgb,
  input  logic [7:0]        brightness,
  input  logic              frame_req,
  output logic              busy,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [23:0]       px_data,
  output logic              px_last,
  output logic              frame_done
);

  // state   | meaning
  // IDLE    | waiting for frame_req
  // FETCH   | copy colour register idx into the holding register
  // SCALE   | apply latched brightness, build the {G,R,B} word
  // PRESENT | word offered to the serializer until accepted
  // DONE    | one-cycle frame_done pulse, then back to IDLE
  typedef enum logic [2:0] {IDLE, FETCH, SCALE, PRESENT, DONE} state_t;

  localparam int IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LED_COUNT - 1);
  localparam logic [ADDR_W:0]   LED_CNT_A = (ADDR_W + 1)'(LED_COUNT);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       bri_q, bri_d;
  logic [23:0]      hold_q, hold_d;
  logic [23:0]      regs_q [LED_COUNT];
  logic [23:0]      regs_d [LED_COUNT];
  logic [23:0]      px_data_q, px_data_d;
  logic             px_valid_q, px_valid_d;
  logic             px_last_q, px_last_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic [IDX_W-1:0] wr_idx;
  logic             wr_ok;
  logic [8:0]       bri_factor;

  assign wr_idx     = wr_addr[IDX_W-1:0];
  assign wr_ok      = wr_en && ({1'b0, wr_addr} < LED_CNT_A);
  assign bri_factor = {1'b0, bri_q} + 9'd1;

  // 255 maps to a factor of 256, so full brightness passes the colour unchanged.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] f);
    logic [15:0] prod;
    prod = 16'(c) * 16'(f);
    return prod[15:8];
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bri_d        = bri_q;
    hold_d       = hold_q;
    regs_d       = regs_q;
    px_data_d    = px_data_q;
    px_valid_d   = px_valid_q;
    px_last_d    = px_last_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    if (wr_ok) regs_d[wr_idx] = wr_rgb;

    unique case (state_q)
      IDLE: begin
        if (frame_req) begin
          state_d = FETCH;
          idx_d   = '0;
          bri_d   = brightness;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        hold_d  = regs_q[idx_q];
        state_d = SCALE;
      end
      SCALE: begin
        px_data_d  = {scale_ch(hold_q[15:8], bri_factor),
                      scale_ch(hold_q[23:16], bri_factor),
                      scale_ch(hold_q[7:0], bri_factor)};
        px_last_d  = (idx_q == LAST_IDX);
        px_valid_d = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (px_ready) begin
          px_valid_d = 1'b0;
          if (px_last_q) begin
            state_d      = DONE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      bri_q        <= '0;
      hold_q       <= '0;
      regs_q       <= '{default: '0};
      px_data_q    <= '0;
      px_valid_q   <= 1'b0;
      px_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bri_q        <= bri_d;
      hold_q       <= hold_d;
      regs_q       <= regs_d;
      px_data_q    <= px_data_d;
      px_valid_q   <= px_valid_d;
      px_last_q    <= px_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign px_valid   = px_valid_q;
  assign px_data    = px_data_q;
  assign px_last    = px_last_q;
  assign frame_done = frame_done_q;

endmodule
